// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: FSM state encoding, instruction size, default vectors.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural fetch PC: reset-load, explicit load (redirect/trap) and +INSTR_BYTES increment.
// Load wins over increment so a redirect taken alongside a decode transfer lands on the target.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [31:0] load_pc,
  input  logic        inc_en,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_pc;
    end else if (inc_en) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer, one outstanding imem request; REQ->WAIT->OUT gives 1 instr / 3 cycles with 1-cycle imem.
// Stalls in REQ on !imem_req_ready, holds OUT on !if_ready; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  pc;
  logic [31:0]  redirect_tgt;
  logic         pc_inc;
  logic         req_hs;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault_q, fetch_fault_d;

  always_comb begin
    redirect_tgt  = redirect_pc;
    fetch_fault_d = 1'b0;
    if (redirect_pc[1:0] != 2'b00) begin
      redirect_tgt  = TRAP_VECTOR;
      fetch_fault_d = redirect_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign fetch_fault = fetch_fault_q;
`else
  logic unused_misalign;

  assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign unused_misalign = ^{redirect_pc[1:0], TRAP_VECTOR};
`endif

  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign if_valid       = (state_q == S_OUT) && !reset;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

  // Every redirect loads the PC; the FSM only decides what happens to in-flight work.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    pc_inc     = 1'b0;
    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end else if (halt) begin
          state_d = S_HALT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_OUT;
            if_pc_d    = pc;
            if_instr_d = imem_rsp_data;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_inc  = 1'b1;
          state_d = halt ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if (!halt) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      kill_q     <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (redirect_valid),
    .load_pc (redirect_tgt),
    .inc_en  (pc_inc),
    .pc      (pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic against a transaction-level PC model.
module tb_fetch_controller;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memory: answers each accepted request mem_lat cycles later, one-cycle response pulse.
  initial begin
    logic        hs_s, rst_s, pend;
    logic [31:0] addr_s, pa;
    int          left;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pend = 1'b0; left = 0; pa = 32'h0;
    forever begin
      @(negedge clk);
      hs_s   = imem_req_valid && imem_req_ready;
      rst_s  = reset;
      addr_s = imem_req_addr;
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (hs_s) begin
          pend = 1'b1; left = mem_lat; pa = addr_s;
        end
        if (pend) begin
          left--;
          if (left == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pa);
            pend = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench just after the edge that released reset; next sample is the first S_REQ cycle.
  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
    if_ready = 1'b1; imem_req_ready = 1'b1;
    drive_edge(); drive_edge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_edge(); drive_edge();
    sample();
    n_checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || fetch_fault !== 1'b0)
      begin n_fail++; $display("FAIL reset_ctrl: req_valid=%b if_valid=%b fault=%b required 0 0 0", imem_req_valid, if_valid, fetch_fault); end
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0)
      begin n_fail++; $display("FAIL reset_data: if_pc=%h if_instr=%h required 0 0", if_pc, if_instr); end
    drive_edge();
    reset = 1'b0;
    sample();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RV)
      begin n_fail++; $display("FAIL reset_first_req: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RV); end
  endtask

  task automatic test_throughput();
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) drive_edge();
      sample();
      n_checks++;
      if (if_valid !== 1'((k % 3) == 2))
        begin n_fail++; $display("FAIL tput_if_valid k=%0d: got %b required %b", k, if_valid, (k % 3) == 2); end
      n_checks++;
      if (imem_req_valid !== 1'((k % 3) == 0))
        begin n_fail++; $display("FAIL tput_req_valid k=%0d: got %b required %b", k, imem_req_valid, (k % 3) == 0); end
      if ((k % 3) == 0) begin
        n_checks++;
        if (imem_req_addr !== 32'(4 * (k / 3)))
          begin n_fail++; $display("FAIL tput_addr k=%0d: got %h required %h", k, imem_req_addr, 32'(4 * (k / 3))); end
      end
      if ((k % 3) == 2) begin
        n_checks++;
        if (if_pc !== 32'(4 * (k / 3)) || if_instr !== mem_word(32'(4 * (k / 3))))
          begin n_fail++; $display("FAIL tput_out k=%0d: pc=%h instr=%h required %h %h", k, if_pc, if_instr, 32'(4 * (k / 3)), mem_word(32'(4 * (k / 3)))); end
      end
    end
  endtask

  task automatic test_req_stall();
    bit got;
    mem_lat = 1;
    do_reset();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) drive_edge();
      sample();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RV || if_valid !== 1'b0)
        begin n_fail++; $display("FAIL req_stall k=%0d: valid=%b addr=%h if_valid=%b required 1 %h 0", k, imem_req_valid, imem_req_addr, if_valid, RV); end
    end
    drive_edge();
    imem_req_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive_edge(); sample();
      if (if_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || if_pc !== RV)
      begin n_fail++; $display("FAIL req_stall_release: seen=%b if_pc=%h required 1 %h", got, if_pc, RV); end
  endtask

  task automatic test_redirect_wait();
    bit got, early;
    mem_lat = 3;
    do_reset();
    sample();
    drive_edge();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    sample();
    n_checks++;
    if (imem_req_valid !== 1'b0)
      begin n_fail++; $display("FAIL redir_wait_state: req_valid=%b required 0", imem_req_valid); end
    drive_edge();
    redirect_valid = 1'b0;
    got = 1'b0; early = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      sample();
      if (imem_req_valid && imem_req_ready) got = 1'b1;
      else begin
        if (if_valid) early = 1'b1;
        drive_edge();
      end
    end
    n_checks++;
    if (!got || early || imem_req_addr !== 32'h0000_0200)
      begin n_fail++; $display("FAIL redir_wait_req: seen=%b stale_out=%b addr=%h required 1 0 00000200", got, early, imem_req_addr); end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      drive_edge(); sample();
      if (if_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || if_pc !== 32'h0000_0200 || if_instr !== mem_word(32'h0000_0200))
      begin n_fail++; $display("FAIL redir_wait_out: seen=%b pc=%h instr=%h required 1 00000200 %h", got, if_pc, if_instr, mem_word(32'h200)); end
    mem_lat = 1;
  endtask

  task automatic test_out_stall();
    bit got;
    logic [31:0] p, ins;
    mem_lat = 2;
    do_reset();
    if_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      sample();
      if (if_valid) got = 1'b1; else drive_edge();
    end
    p = if_pc; ins = if_instr;
    n_checks++;
    if (!got || p !== RV || ins !== mem_word(RV))
      begin n_fail++; $display("FAIL out_stall_first: seen=%b pc=%h instr=%h required 1 %h %h", got, p, ins, RV, mem_word(RV)); end
    for (int k = 0; k < 4; k++) begin
      drive_edge(); sample();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== p || if_instr !== ins || imem_req_valid !== 1'b0)
        begin n_fail++; $display("FAIL out_stall_hold k=%0d: if_valid=%b pc=%h instr=%h req_valid=%b required 1 %h %h 0", k, if_valid, if_pc, if_instr, imem_req_valid, p, ins); end
    end
    drive_edge();
    if_ready = 1'b1;
    sample();
    drive_edge(); sample();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RV + 32'd4)
      begin n_fail++; $display("FAIL out_stall_next: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RV + 32'd4); end
    mem_lat = 1;
  endtask

  task automatic test_misalign();
    bit got;
    mem_lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    sample();
    drive_edge();
    redirect_valid = 1'b0;
    sample();
    n_checks++;
    if (fetch_fault !== TRAP_EN)
      begin n_fail++; $display("FAIL misalign_fault: got %b required %b", fetch_fault, TRAP_EN); end
    drive_edge(); sample();
    n_checks++;
    if (fetch_fault !== 1'b0)
      begin n_fail++; $display("FAIL misalign_fault_pulse: got %b required 0", fetch_fault); end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100)
      begin n_fail++; $display("FAIL misalign_addr: valid=%b addr=%h required 1 00000100", imem_req_valid, imem_req_addr); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive_edge(); sample();
      if (if_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || if_pc !== 32'h0000_0100)
      begin n_fail++; $display("FAIL misalign_out: seen=%b pc=%h required 1 00000100", got, if_pc); end
  endtask

  task automatic test_wrap();
    bit got;
    mem_lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive_edge();
    redirect_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      sample();
      if (if_valid) got = 1'b1; else drive_edge();
    end
    n_checks++;
    if (!got || if_pc !== 32'hFFFF_FFFC || if_instr !== mem_word(32'hFFFF_FFFC))
      begin n_fail++; $display("FAIL wrap_out: seen=%b pc=%h instr=%h required 1 fffffffc %h", got, if_pc, if_instr, mem_word(32'hFFFF_FFFC)); end
    drive_edge(); sample();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
      begin n_fail++; $display("FAIL wrap_addr: valid=%b addr=%h required 1 00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_halt();
    mem_lat = 1;
    do_reset();
    imem_req_ready = 1'b0; halt = 1'b1;
    sample();
    drive_edge();
    imem_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      redirect_valid = (k == 4); redirect_pc = 32'h0000_0040;
      sample();
      n_checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0)
        begin n_fail++; $display("FAIL halt_idle k=%0d: req_valid=%b if_valid=%b required 0 0", k, imem_req_valid, if_valid); end
      drive_edge();
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
    sample();
    drive_edge(); sample();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0040)
      begin n_fail++; $display("FAIL halt_resume: valid=%b addr=%h required 1 00000040", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    bit got;
    mem_lat = 2;
    do_reset();
    sample();
    drive_edge();
    reset = 1'b1;
    sample();
    n_checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid_gate: req_valid=%b if_valid=%b required 0 0", imem_req_valid, if_valid); end
    drive_edge();
    reset = 1'b0;
    sample();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RV || if_pc !== 32'h0)
      begin n_fail++; $display("FAIL reset_mid_restart: valid=%b addr=%h if_pc=%h required 1 %h 0", imem_req_valid, imem_req_addr, if_pc, RV); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive_edge(); sample();
      if (if_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || if_pc !== RV || if_instr !== mem_word(RV))
      begin n_fail++; $display("FAIL reset_mid_out: seen=%b pc=%h instr=%h required 1 %h %h", got, if_pc, if_instr, RV, mem_word(RV)); end
    mem_lat = 1;
  endtask

  // Model: the stream of delivered PCs is sequential from the reset vector, restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, hold_pc, hold_instr, tgt;
    bit outstanding, prev_hold, exp_fault, hs, xfer, mis;
    int n_xfer;
    do_reset();
    exp_pc = RV; outstanding = 1'b0; prev_hold = 1'b0; exp_fault = 1'b0; n_xfer = 0;
    hold_pc = 32'h0; hold_instr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        drive_edge();
        imem_req_ready = ($urandom % 4) != 0;
        if_ready       = ($urandom % 3) != 0;
        redirect_valid = ($urandom % 12) == 0;
        case ($urandom % 4)
          0:       redirect_pc = $urandom;
          1:       redirect_pc = $urandom & 32'hFFFF_FFFC;
          2:       redirect_pc = 32'hFFFF_FFF8 | ($urandom & 32'h7);
          default: redirect_pc = ($urandom % 64) * 4;
        endcase
        halt = halt ? (($urandom % 6) != 0) : (($urandom % 40) == 0);
        if (($urandom % 50) == 0) mem_lat = 1 + ($urandom % 3);
      end
      sample();
      hs   = imem_req_valid && imem_req_ready;
      xfer = if_valid && if_ready;
      if (hs) begin
        n_checks++;
        if (outstanding || imem_req_addr !== exp_pc)
          begin n_fail++; $display("FAIL rand_req cyc=%0d: addr=%h outstanding=%b required %h 0", cyc, imem_req_addr, outstanding, exp_pc); end
      end
      if (xfer) begin
        n_checks++;
        if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc))
          begin n_fail++; $display("FAIL rand_xfer cyc=%0d: pc=%h instr=%h required %h %h", cyc, if_pc, if_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
      if (prev_hold) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== hold_pc || if_instr !== hold_instr)
          begin n_fail++; $display("FAIL rand_hold cyc=%0d: if_valid=%b pc=%h instr=%h required 1 %h %h", cyc, if_valid, if_pc, if_instr, hold_pc, hold_instr); end
      end
      n_checks++;
      if (fetch_fault !== exp_fault)
        begin n_fail++; $display("FAIL rand_fault cyc=%0d: got %b required %b", cyc, fetch_fault, exp_fault); end
      mis = redirect_pc[1:0] != 2'b00;
      exp_fault = redirect_valid && mis && TRAP_EN;
      if (redirect_valid) begin
        tgt = redirect_pc;
        if (mis) tgt = TRAP_EN ? TV : {redirect_pc[31:2], 2'b00};
        exp_pc = tgt;
      end
      prev_hold  = if_valid && !if_ready && !redirect_valid;
      hold_pc    = if_pc;
      hold_instr = if_instr;
      if (imem_rsp_valid) outstanding = 1'b0;
      if (hs) outstanding = 1'b1;
    end
    n_checks++;
    if (n_xfer < 50)
      begin n_fail++; $display("FAIL rand_progress: %0d transfers required at least 50", n_xfer); end
    redirect_valid = 1'b0; halt = 1'b0; mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_req_stall();
    test_redirect_wait();
    test_out_stall();
    test_misalign();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
